// File: rtl/bitrev_pkg.sv
// Shared constants, state encoding and bit-reverse helper for the bitrev SPI master.
package bitrev_pkg;
   localparam int BITS         = 8;
   localparam int XFER_PERIODS = 16;

   typedef logic [2:0] state_t;
   localparam state_t ST_IDLE  = 3'd0;
   localparam state_t ST_SETUP = 3'd1;
   localparam state_t ST_SHIFT = 3'd2;
   localparam state_t ST_HOLD  = 3'd3;
   localparam state_t ST_RESP  = 3'd4;
   localparam state_t ST_GAP   = 3'd5;

   function automatic logic [BITS-1:0] bitrev8(input logic [BITS-1:0] d);
      logic [BITS-1:0] r;
      for (int i = 0; i < BITS; i++) r[i] = d[BITS-1-i];
      return r;
   endfunction
endpackage

// File: rtl/bitrev_master_if.sv
// Requester and response channels of the bitrev SPI master.
interface bitrev_master_if;
   import bitrev_pkg::*;

   // valid/ready: a transfer happens on the rising clock edge where both are high;
   // once valid is raised, the payload holds steady until that edge.
   logic            req0_valid;
   logic [BITS-1:0] req0_data;
   logic            req0_ready;
   logic            req1_valid;
   logic [BITS-1:0] req1_data;
   logic            req1_ready;
   logic            rsp_valid;
   logic            rsp_ready;
   logic            rsp_id;
   logic [BITS-1:0] rsp_data;
   logic            rsp_err;

   modport master (
      output req0_valid, req0_data, req1_valid, req1_data, rsp_ready,
      input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data, rsp_err
   );

   modport slave (
      input  req0_valid, req0_data, req1_valid, req1_data, rsp_ready,
      output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data, rsp_err
   );
endinterface

// File: rtl/bitrev_rr_arb.sv
// Two-way round-robin arbiter; the pointer holds the last requester served.
module bitrev_rr_arb (
   input  logic       clock,
   input  logic       resetn,
   input  logic [1:0] i_valid,
   input  logic       i_en,
   input  logic       i_hs,
   output logic [1:0] o_gnt,
   output logic       o_gnt_id
);
   logic r_last;
   logic w_id;

   always_comb begin
      w_id = 1'b0;
      if (i_valid == 2'b11) w_id = ~r_last;
      else if (i_valid[1])  w_id = 1'b1;
   end

   always_comb begin
      o_gnt = 2'b00;
      if (i_en && (|i_valid)) o_gnt = w_id ? 2'b10 : 2'b01;
   end

   assign o_gnt_id = w_id;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn)   r_last <= 1'b1;
      else if (i_hs) r_last <= w_id;
   end
endmodule

// File: rtl/bitrev_master.sv
// SPI master/scheduler for the bit-reversal peripheral: 8 bits out, 8 bits back per grant.
// Optional self-check comparator enabled by BITREV_MASTER_CHECK_EN.
module bitrev_master
   import bitrev_pkg::*;
#(
   parameter int DIV = 2,
   parameter int GAP = 2
) (
   input  logic           clock,
   input  logic           resetn,
   bitrev_master_if.slave bus,
   output logic           busy,
   output logic           sck,
   output logic           ss,
   output logic           mosi,
   input  logic           miso
);
   localparam logic [7:0] DIV_LAST = 8'(DIV - 1);
   localparam logic [7:0] GAP_LAST = 8'(GAP - 1);
   localparam logic [3:0] BIT_LAST = 4'(XFER_PERIODS - 1);

   state_t          r_state;
   logic [7:0]      r_cnt;
   logic [3:0]      r_bit;
   logic            r_half;
   logic            r_sck;
   logic            r_ss;
   logic            r_mosi;
   logic            r_id;
   logic            r_rsp_valid;
   logic [BITS-1:0] r_sh;
   logic [BITS-1:0] r_rx;

   logic [1:0]      w_valid;
   logic [1:0]      w_gnt;
   logic            w_gnt_id;
   logic            w_idle;
   logic            w_hs;
   logic            w_div_done;
   logic [BITS-1:0] w_tx;

   assign w_valid    = {bus.req1_valid, bus.req0_valid};
   assign w_idle     = (r_state == ST_IDLE);
   assign w_hs       = |(w_valid & w_gnt);
   assign w_tx       = w_gnt_id ? bus.req1_data : bus.req0_data;
   assign w_div_done = (r_cnt == DIV_LAST);

   bitrev_rr_arb u_arb (
      .clock    (clock),
      .resetn   (resetn),
      .i_valid  (w_valid),
      .i_en     (w_idle),
      .i_hs     (w_hs),
      .o_gnt    (w_gnt),
      .o_gnt_id (w_gnt_id)
   );

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_state     <= ST_IDLE;
         r_cnt       <= 8'd0;
         r_bit       <= 4'd0;
         r_half      <= 1'b0;
         r_sck       <= 1'b0;
         r_ss        <= 1'b1;
         r_mosi      <= 1'b0;
         r_id        <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_sh        <= '0;
         r_rx        <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_hs) begin
                  r_state <= ST_SETUP;
                  r_cnt   <= 8'd0;
                  r_ss    <= 1'b0;
                  r_id    <= w_gnt_id;
                  r_sh    <= w_tx;
                  r_mosi  <= w_tx[BITS-1];
               end
            end
            ST_SETUP: begin
               if (w_div_done) begin
                  r_state <= ST_SHIFT;
                  r_cnt   <= 8'd0;
                  r_bit   <= 4'd0;
                  r_half  <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            ST_SHIFT: begin
               if (!w_div_done) begin
                  r_cnt <= r_cnt + 8'd1;
               end else begin
                  r_cnt <= 8'd0;
                  if (!r_half) begin
                     // Rising SCK edge: the second byte is captured here.
                     r_half <= 1'b1;
                     r_sck  <= 1'b1;
                     if (r_bit[3]) r_rx <= {r_rx[BITS-2:0], miso};
                  end else begin
                     r_half <= 1'b0;
                     r_sck  <= 1'b0;
                     if (r_bit == BIT_LAST) begin
                        r_state <= ST_HOLD;
                        r_bit   <= 4'd0;
                        r_mosi  <= 1'b0;
                     end else begin
                        // Zero-filled shift makes mosi 0 for the receive half.
                        r_bit  <= r_bit + 4'd1;
                        r_sh   <= {r_sh[BITS-2:0], 1'b0};
                        r_mosi <= r_sh[BITS-2];
                     end
                  end
               end
            end
            ST_HOLD: begin
               if (w_div_done) begin
                  r_state     <= ST_RESP;
                  r_cnt       <= 8'd0;
                  r_ss        <= 1'b1;
                  r_rsp_valid <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            ST_RESP: begin
               if (bus.rsp_ready) begin
                  r_state     <= ST_GAP;
                  r_cnt       <= 8'd0;
                  r_rsp_valid <= 1'b0;
               end
            end
            ST_GAP: begin
               if (r_cnt == GAP_LAST) begin
                  r_state <= ST_IDLE;
                  r_cnt   <= 8'd0;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

`ifdef BITREV_MASTER_CHECK_EN
   logic [BITS-1:0] r_tx;
   logic            r_err;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_tx  <= '0;
         r_err <= 1'b0;
      end else begin
         if (w_hs) r_tx <= w_tx;
         if (r_state == ST_HOLD && w_div_done)       r_err <= (r_rx != bitrev8(r_tx));
         else if (r_state == ST_RESP && bus.rsp_ready) r_err <= 1'b0;
      end
   end

   assign bus.rsp_err = r_err;
`else
   assign bus.rsp_err = 1'b0;
`endif

   assign bus.req0_ready = w_gnt[0];
   assign bus.req1_ready = w_gnt[1];
   assign bus.rsp_valid  = r_rsp_valid;
   assign bus.rsp_id     = r_id;
   assign bus.rsp_data   = r_rx;
   assign busy           = ~w_idle;
   assign sck            = r_sck;
   assign ss             = r_ss;
   assign mosi           = r_mosi;
endmodule

// File: tb/tb_bitrev_master.sv
// Directed bench for bitrev_master with a bit-reversing SPI slave model.
module tb_bitrev_master;
   import bitrev_pkg::*;

   localparam int DIV    = 2;
   localparam int GAP    = 2;
   localparam int LAT    = 34 * DIV + 1;
   localparam int PERIOD = 34 * DIV + GAP + 2;

   // clock / reset
   logic clock  = 1'b0;
   logic resetn = 1'b0;
   always #5 clock = ~clock;

   logic busy, sck, ss, mosi, miso;
   bitrev_master_if bus ();

   bitrev_master #(.DIV(DIV), .GAP(GAP)) dut (
      .clock  (clock),
      .resetn (resetn),
      .bus    (bus),
      .busy   (busy),
      .sck    (sck),
      .ss     (ss),
      .mosi   (mosi),
      .miso   (miso)
   );

   int n_cmp  = 0;
   int n_fail = 0;
   int cyc    = 0;
   always @(posedge clock) cyc <= cyc + 1;

   // slave model: shifts in 8 bits, returns them reversed MSB first
   logic [7:0] s_in     = 8'h00;
   logic [7:0] s_out    = 8'h00;
   int         s_cnt    = 0;
   int         s_tail_bad = 0;
   logic       s_force  = 1'b0;
   initial miso = 1'b0;

   always @(posedge ss) s_cnt = 0;
   always @(posedge sck) begin
      if (!ss) begin
         if (s_cnt < 8) s_in = {s_in[6:0], mosi};
         else if (mosi !== 1'b0) s_tail_bad++;
         s_cnt++;
         if (s_cnt == 8) s_out = bitrev8(s_in);
      end
   end
   always @(negedge sck) begin
      if (!ss && s_cnt >= 8 && s_cnt < 16) miso = s_force ? 1'b1 : s_out[15 - s_cnt];
   end

   // monitor logs and scoreboard queues
   logic       g_id_q[$];
   int         g_cyc_q[$];
   int         g_run_q[$];
   logic [9:0] rsp_q[$];
   int         r_cyc_q[$];
   logic [9:0] exp_q[$];
   int         ss_run = 0;

   always @(negedge clock) begin
      if (!resetn) begin
         ss_run = 0;
      end else begin
         if (ss) ss_run++;
         else    ss_run = 0;
         if (bus.req0_valid && bus.req0_ready) begin
            g_id_q.push_back(1'b0); g_cyc_q.push_back(cyc); g_run_q.push_back(ss_run);
         end
         if (bus.req1_valid && bus.req1_ready) begin
            g_id_q.push_back(1'b1); g_cyc_q.push_back(cyc); g_run_q.push_back(ss_run);
         end
         if (bus.rsp_valid && bus.rsp_ready) begin
            rsp_q.push_back({bus.rsp_err, bus.rsp_id, bus.rsp_data});
            r_cyc_q.push_back(cyc);
         end
      end
   end

   logic [7:0] tx0_q[$];
   logic [7:0] tx1_q[$];

   // driver tasks
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic clear_logs();
      g_id_q.delete(); g_cyc_q.delete(); g_run_q.delete();
      rsp_q.delete(); r_cyc_q.delete(); exp_q.delete();
   endtask

   task automatic load_reqs();
      bus.req0_valid = (tx0_q.size() > 0);
      bus.req0_data  = (tx0_q.size() > 0) ? tx0_q[0] : 8'h00;
      bus.req1_valid = (tx1_q.size() > 0);
      bus.req1_data  = (tx1_q.size() > 0) ? tx1_q[0] : 8'h00;
   endtask

   task automatic run_reqs(input int budget);
      int   k;
      logic hs0, hs1;
      k = 0;
      load_reqs();
      while ((tx0_q.size() > 0 || tx1_q.size() > 0) && k < budget) begin
         @(negedge clock);
         hs0 = bus.req0_valid && bus.req0_ready;
         hs1 = bus.req1_valid && bus.req1_ready;
         tick();
         k++;
         if (hs0) void'(tx0_q.pop_front());
         if (hs1) void'(tx1_q.pop_front());
         load_reqs();
      end
      n_cmp++;
      if (tx0_q.size() + tx1_q.size() != 0) begin
         n_fail++;
         $display("FAIL req_timeout: %0d bytes not accepted, required 0", tx0_q.size() + tx1_q.size());
      end
      tx0_q.delete(); tx1_q.delete();
      load_reqs();
   endtask

   task automatic wait_rsps(input int n, input int budget);
      int k;
      k = 0;
      while (rsp_q.size() < n && k < budget) begin
         tick();
         k++;
      end
      n_cmp++;
      if (rsp_q.size() < n) begin
         n_fail++;
         $display("FAIL rsp_timeout: %0d responses, required %0d", rsp_q.size(), n);
      end
   endtask

   task automatic test_reset();
      repeat (3) tick();
      n_cmp++;
      if ({sck, ss, mosi} !== 3'b010) begin
         n_fail++; $display("FAIL reset_spi: sck/ss/mosi %b, required 010", {sck, ss, mosi});
      end
      n_cmp++;
      if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_err} !== 11'h000) begin
         n_fail++; $display("FAIL reset_rsp: %h, required 000", {bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_err});
      end
      n_cmp++;
      if ({busy, bus.req0_ready, bus.req1_ready} !== 3'b000) begin
         n_fail++; $display("FAIL reset_ctrl: busy/rdy0/rdy1 %b, required 000", {busy, bus.req0_ready, bus.req1_ready});
      end
      resetn = 1'b1;
      repeat (2) tick();
      n_cmp++;
      if ({busy, bus.req0_ready, bus.req1_ready, ss} !== 4'b0001) begin
         n_fail++; $display("FAIL idle_no_req: busy/rdy0/rdy1/ss %b, required 0001", {busy, bus.req0_ready, bus.req1_ready, ss});
      end
   endtask

   task automatic test_single();
      clear_logs();
      tx0_q.push_back(8'hA5);
      exp_q.push_back({1'b0, 1'b0, 8'hA5});
      run_reqs(50);
      wait_rsps(1, 400);
      if (rsp_q.size() > 0 && g_cyc_q.size() > 0) begin
         n_cmp++;
         if (r_cyc_q[0] - g_cyc_q[0] !== LAT) begin
            n_fail++; $display("FAIL single_latency: %0d cycles, required %0d", r_cyc_q[0] - g_cyc_q[0], LAT);
         end
         n_cmp++;
         if (rsp_q[0] !== exp_q[0]) begin
            n_fail++; $display("FAIL single_rsp: err/id/data %h, required %h", rsp_q[0], exp_q[0]);
         end
      end
      n_cmp++;
      if (s_tail_bad !== 0) begin
         n_fail++; $display("FAIL mosi_tail: %0d nonzero bits, required 0", s_tail_bad);
      end
   endtask

   task automatic test_pair_from_reset();
      resetn = 1'b0;
      repeat (2) tick();
      resetn = 1'b1;
      tick();
      clear_logs();
      tx0_q.push_back(8'h01);
      tx1_q.push_back(8'h80);
      exp_q.push_back({1'b0, 1'b0, 8'h80});
      exp_q.push_back({1'b0, 1'b1, 8'h01});
      run_reqs(400);
      wait_rsps(2, 400);
      for (int i = 0; i < 2; i++) begin
         n_cmp++;
         if (i >= rsp_q.size() || rsp_q[i] !== exp_q[i]) begin
            n_fail++; $display("FAIL pair_rsp%0d: %h, required %h", i, (i < rsp_q.size()) ? rsp_q[i] : 10'h3ff, exp_q[i]);
         end
      end
      if (g_id_q.size() == 2) begin
         n_cmp++;
         if ({g_id_q[0], g_id_q[1]} !== 2'b01) begin
            n_fail++; $display("FAIL pair_order: %b, required 01", {g_id_q[0], g_id_q[1]});
         end
         n_cmp++;
         if (g_run_q[1] < GAP) begin
            n_fail++; $display("FAIL pair_ss_gap: %0d cycles, required >= %0d", g_run_q[1], GAP);
         end
         n_cmp++;
         if (g_cyc_q[1] - g_cyc_q[0] !== PERIOD) begin
            n_fail++; $display("FAIL pair_period: %0d, required %0d", g_cyc_q[1] - g_cyc_q[0], PERIOD);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0] ids;
      clear_logs();
      tx0_q.push_back(8'h0F); tx0_q.push_back(8'h3C);
      tx1_q.push_back(8'hF0); tx1_q.push_back(8'hC3);
      exp_q.push_back({1'b0, 1'b0, 8'hF0});
      exp_q.push_back({1'b0, 1'b1, 8'h0F});
      exp_q.push_back({1'b0, 1'b0, 8'h3C});
      exp_q.push_back({1'b0, 1'b1, 8'hC3});
      run_reqs(600);
      wait_rsps(4, 400);
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (i >= rsp_q.size() || rsp_q[i] !== exp_q[i]) begin
            n_fail++; $display("FAIL b2b_rsp%0d: %h, required %h", i, (i < rsp_q.size()) ? rsp_q[i] : 10'h3ff, exp_q[i]);
         end
      end
      if (g_id_q.size() == 4) begin
         ids = {g_id_q[0], g_id_q[1], g_id_q[2], g_id_q[3]};
         n_cmp++;
         if (ids !== 4'b0101) begin
            n_fail++; $display("FAIL b2b_order: %b, required 0101", ids);
         end
         for (int i = 1; i < 4; i++) begin
            n_cmp++;
            if (g_cyc_q[i] - g_cyc_q[i-1] !== PERIOD || g_run_q[i] !== GAP + 2) begin
               n_fail++; $display("FAIL b2b_timing%0d: period %0d ss_high %0d, required %0d and %0d",
                                  i, g_cyc_q[i] - g_cyc_q[i-1], g_run_q[i], PERIOD, GAP + 2);
            end
         end
      end
      n_cmp++;
      if (s_tail_bad !== 0) begin
         n_fail++; $display("FAIL b2b_mosi_tail: %0d nonzero bits, required 0", s_tail_bad);
      end
   endtask

   task automatic test_rsp_backpressure();
      int k;
      int bad_ss, bad_valid, bad_payload, bad_rdy;
      clear_logs();
      bus.rsp_ready  = 1'b0;
      bus.req0_valid = 1'b1; bus.req0_data = 8'h33;
      bus.req1_valid = 1'b1; bus.req1_data = 8'h55;
      exp_q.push_back({1'b0, 1'b0, 8'hCC});
      exp_q.push_back({1'b0, 1'b1, 8'hAA});
      k = 0;
      while (g_id_q.size() < 1 && k < 20) begin tick(); k++; end
      bus.req0_valid = 1'b0;
      k = 0;
      while (!bus.rsp_valid && k < 200) begin @(negedge clock); k++; end
      n_cmp++;
      if (bus.rsp_valid !== 1'b1) begin
         n_fail++; $display("FAIL bp_rsp_valid: %b, required 1", bus.rsp_valid);
      end
      bad_ss = 0; bad_valid = 0; bad_payload = 0; bad_rdy = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         if (ss !== 1'b1) bad_ss++;
         if (bus.rsp_valid !== 1'b1) bad_valid++;
         if ({bus.rsp_err, bus.rsp_id, bus.rsp_data} !== exp_q[0]) bad_payload++;
         if (bus.req1_ready !== 1'b0) bad_rdy++;
      end
      n_cmp++;
      if (bad_ss + bad_valid !== 0) begin
         n_fail++; $display("FAIL bp_hold: ss low %0d, valid low %0d samples, required 0", bad_ss, bad_valid);
      end
      n_cmp++;
      if (bad_payload !== 0) begin
         n_fail++; $display("FAIL bp_stable: %0d unstable samples, required 0", bad_payload);
      end
      n_cmp++;
      if (bad_rdy !== 0 || g_id_q.size() !== 1) begin
         n_fail++; $display("FAIL bp_no_grant: rdy1 %0d samples, grants %0d, required 0 and 1", bad_rdy, g_id_q.size());
      end
      tick();
      bus.rsp_ready = 1'b1;
      k = 0;
      while (g_id_q.size() < 2 && k < 50) begin tick(); k++; end
      bus.req1_valid = 1'b0;
      wait_rsps(2, 400);
      for (int i = 0; i < 2; i++) begin
         n_cmp++;
         if (i >= rsp_q.size() || rsp_q[i] !== exp_q[i]) begin
            n_fail++; $display("FAIL bp_rsp%0d: %h, required %h", i, (i < rsp_q.size()) ? rsp_q[i] : 10'h3ff, exp_q[i]);
         end
      end
      if (g_cyc_q.size() == 2 && r_cyc_q.size() > 0) begin
         n_cmp++;
         if (g_cyc_q[1] - r_cyc_q[0] !== GAP + 1) begin
            n_fail++; $display("FAIL bp_regrant: %0d cycles after rsp, required %0d", g_cyc_q[1] - r_cyc_q[0], GAP + 1);
         end
      end
   endtask

   task automatic test_reset_mid_shift();
      int   k, falls;
      logic prev;
      clear_logs();
      tx0_q.push_back(8'h77);
      run_reqs(50);
      falls = 0; k = 0; prev = sck;
      while (falls < 5 && k < 500) begin
         @(negedge clock);
         if (prev && !sck) falls++;
         prev = sck;
         k++;
      end
      n_cmp++;
      if (falls !== 5 || busy !== 1'b1) begin
         n_fail++; $display("FAIL abort_setup: falls %0d busy %b, required 5 and 1", falls, busy);
      end
      resetn = 1'b0;
      #1;
      n_cmp++;
      if ({sck, ss, mosi, bus.rsp_valid, busy} !== 5'b01000) begin
         n_fail++; $display("FAIL abort_outputs: sck/ss/mosi/rsp_valid/busy %b, required 01000",
                            {sck, ss, mosi, bus.rsp_valid, busy});
      end
      repeat (2) tick();
      resetn = 1'b1;
      repeat (100) tick();
      n_cmp++;
      if (rsp_q.size() !== 0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL abort_no_rsp: %0d responses busy %b, required 0 and 0", rsp_q.size(), busy);
      end
      clear_logs();
      tx0_q.push_back(8'h5A);
      exp_q.push_back({1'b0, 1'b0, 8'h5A});
      run_reqs(50);
      wait_rsps(1, 400);
      n_cmp++;
      if (rsp_q.size() < 1 || rsp_q[0] !== exp_q[0]) begin
         n_fail++; $display("FAIL abort_recover: %h, required %h", (rsp_q.size() > 0) ? rsp_q[0] : 10'h3ff, exp_q[0]);
      end
   endtask

   task automatic test_self_check();
      clear_logs();
      s_force = 1'b1;
`ifdef BITREV_MASTER_CHECK_EN
      exp_q.push_back({1'b1, 1'b0, 8'hFF});
`else
      exp_q.push_back({1'b0, 1'b0, 8'hFF});
`endif
      tx0_q.push_back(8'h12);
      run_reqs(50);
      wait_rsps(1, 400);
      s_force = 1'b0;
      n_cmp++;
      if (rsp_q.size() < 1 || rsp_q[0] !== exp_q[0]) begin
         n_fail++; $display("FAIL check_err: %h, required %h", (rsp_q.size() > 0) ? rsp_q[0] : 10'h3ff, exp_q[0]);
      end
   endtask

   initial begin
      bus.req0_valid = 1'b0; bus.req0_data = 8'h00;
      bus.req1_valid = 1'b0; bus.req1_data = 8'h00;
      bus.rsp_ready  = 1'b1;
      test_reset();
      test_single();
      test_pair_from_reset();
      test_back_to_back();
      test_rsp_backpressure();
      test_reset_mid_shift();
      test_self_check();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
